// File: rtl/aes_pkg.sv
// Shared widths, FSM encoding and GF(2^8) helpers for the AES column-mix stage.
package aes_pkg;
    localparam int HDR_W   = 4;
    localparam int STATE_W = 128;
    localparam int PKT_W   = 132;
    localparam int COL_W   = 32;
    localparam int NUM_COL = STATE_W / COL_W;

    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef struct packed {
        logic [HDR_W-1:0]   hdr;
        logic [STATE_W-1:0] st;
    } pkt_t;

    // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/mix_single_column.sv
// One AES MixColumns column: four bytes, b0 in the most significant byte.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] x0, x1, x2, x3;

    assign {b0, b1, b2, b3} = col_in;
    assign x0 = xtime(b0);
    assign x1 = xtime(b1);
    assign x2 = xtime(b2);
    assign x3 = xtime(b3);

    // 3b is written as xtime(b)^b
    assign col_out = {x0 ^ (x1 ^ b1) ^ b2 ^ b3,
                      b0 ^ x1 ^ (x2 ^ b2) ^ b3,
                      b0 ^ b1 ^ x2 ^ (x3 ^ b3),
                      (x0 ^ b0) ^ b1 ^ b2 ^ x3};
endmodule

// File: rtl/mix_columns.sv
// Iterative AES MixColumns: one column per cycle, four cycles per block,
// with a last-round bypass that keeps latency unchanged.
module mix_columns
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PKT_W-1:0] data_in,
    input  logic             last_round,
    output logic [PKT_W-1:0] data_out,
    output logic             done,
    output logic             busy
);
    state_e             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [STATE_W-1:0] st_q, st_d, st_mix;
    logic               lr_q, lr_d;
    pkt_t               dout_q, dout_d;
    pkt_t               pin;
    logic [COL_W-1:0]   col_sel, col_mixed, col_new;

    assign pin = pkt_t'(data_in);

    always_comb begin
        col_sel = '0;
        for (int c = 0; c < NUM_COL; c++)
            if (col_q == 2'(c)) col_sel = st_q[STATE_W-1-COL_W*c -: COL_W];
    end

    mix_single_column u_mix (
        .col_in  (col_sel),
        .col_out (col_mixed)
    );

    assign col_new = lr_q ? col_sel : col_mixed;

    always_comb begin
        st_mix = st_q;
        for (int c = 0; c < NUM_COL; c++)
            if (col_q == 2'(c)) st_mix[STATE_W-1-COL_W*c -: COL_W] = col_new;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        hdr_d   = hdr_q;
        st_d    = st_q;
        lr_d    = lr_q;
        dout_d  = dout_q;
        // load wins in every state; a zero header flushes instead of starting
        if (load) begin
            col_d = '0;
            if (pin.hdr != '0) begin
                state_d = RUN;
                hdr_d   = pin.hdr;
                st_d    = pin.st;
                lr_d    = last_round;
            end else begin
                state_d = IDLE;
                dout_d  = '0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    st_d  = st_mix;
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_d = DONE;
                        dout_d  = '{hdr: hdr_q, st: st_mix};
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            hdr_q   <= '0;
            st_q    <= '0;
            lr_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            hdr_q   <= hdr_d;
            st_q    <= st_d;
            lr_q    <= lr_d;
            dout_q  <= dout_d;
        end
    end

    assign data_out = dout_q;
    assign done     = (state_q == DONE);
    assign busy     = (state_q == RUN);
endmodule
